// File: rtl/fbuf_arb_pkg.sv
// Shared types for the frame-buffer read arbiter: owner tags, FSM state codes, default widths.
package fbuf_arb_pkg;

    localparam int DEF_ADDR_BITS = 17;
    localparam int DEF_DATA_BITS = 12;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_ANA  = 2'd2
    } owner_e;

    localparam logic [0:0] PRIO_DISP = 1'b0;
    localparam logic [0:0] FORCE_ANA = 1'b1;

    function automatic owner_e grant_owner(input logic disp_gnt, input logic ana_gnt);
        if (disp_gnt)
            return OWN_DISP;
        else if (ana_gnt)
            return OWN_ANA;
        else
            return OWN_NONE;
    endfunction

endpackage

// File: rtl/fbuf_read_arbiter_if.sv
// Request/grant/return bundle between the two frame-buffer readers, the arbiter and the BRAM port.
// master: requesters and BRAM model side; slave: the arbiter.
interface fbuf_read_arbiter_if
    import fbuf_arb_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic                 disp_req;
    logic [ADDR_BITS-1:0] disp_addr;
    logic                 disp_gnt;
    logic                 disp_rvalid;
    logic [DATA_BITS-1:0] disp_rdata;

    logic                 ana_req;
    logic [ADDR_BITS-1:0] ana_addr;
    logic                 ana_gnt;
    logic                 ana_rvalid;
    logic [DATA_BITS-1:0] ana_rdata;
    logic                 ana_starved;

    logic [ADDR_BITS-1:0] bram_rdaddress;
    logic [DATA_BITS-1:0] bram_rddata;

    modport master (
        output disp_req, disp_addr, ana_req, ana_addr, bram_rddata,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  ana_gnt, ana_rvalid, ana_rdata, ana_starved, bram_rdaddress
    );

    modport slave (
        input  disp_req, disp_addr, ana_req, ana_addr, bram_rddata,
        output disp_gnt, disp_rvalid, disp_rdata,
        output ana_gnt, ana_rvalid, ana_rdata, ana_starved, bram_rdaddress
    );
endinterface

// File: rtl/fbuf_tag_pipe.sv
// Owner-tag delay line matching the BRAM read path; tag_out is valid DEPTH cycles after tag_in.
// No backpressure: advances every cycle, reset flushes all stages to OWN_NONE.
module fbuf_tag_pipe
    import fbuf_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic   clk_25_vga,
    input  logic   rst_n,
    input  owner_e tag_in,
    output owner_e tag_out
);

    owner_e stage [DEPTH];

    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= OWN_NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fbuf_read_arbiter.sv
// Two-port read arbiter for the VGA frame buffer: display wins, optional anti-starvation slot
// (FBUF_ARB_STARVE_GUARD_EN). Grant is combinational, data returns RD_LATENCY+1 cycles after it;
// losers simply hold req/addr, nothing is queued here.
module fbuf_read_arbiter
    import fbuf_arb_pkg::*;
#(
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk_25_vga,
    input  logic              rst_n,
    fbuf_read_arbiter_if.slave bus
);

    logic   disp_gnt;
    logic   ana_gnt;
    owner_e tag_out;

`ifdef FBUF_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_THRESH = 8'(STARVE_LIMIT - 1);

    logic [0:0] state;
    logic [7:0] wait_cnt;
    logic       force_ana;

    assign force_ana = (state == FORCE_ANA);

    always_comb begin
        disp_gnt = 1'b0;
        ana_gnt  = 1'b0;
        if (rst_n) begin
            if (force_ana) begin
                if (bus.ana_req)
                    ana_gnt = 1'b1;
                else if (bus.disp_req)
                    disp_gnt = 1'b1;
            end else begin
                if (bus.disp_req)
                    disp_gnt = 1'b1;
                else if (bus.ana_req)
                    ana_gnt = 1'b1;
            end
        end
    end

    // The forced slot lasts exactly one cycle, whether or not analysis still wants it.
    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PRIO_DISP;
            wait_cnt <= 8'd0;
        end else begin
            if (state == PRIO_DISP && wait_cnt == STARVE_THRESH && bus.disp_req && bus.ana_req)
                state <= FORCE_ANA;
            else
                state <= PRIO_DISP;

            if (!bus.ana_req || ana_gnt)
                wait_cnt <= 8'd0;
            else if (wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign bus.ana_starved = force_ana & ana_gnt;
`else
    assign disp_gnt = rst_n & bus.disp_req;
    assign ana_gnt  = rst_n & bus.ana_req & ~bus.disp_req;

    // STARVE_LIMIT has no effect here; every legal value yields a constant 0.
    assign bus.ana_starved = (STARVE_LIMIT == 0);
`endif

    assign bus.disp_gnt = disp_gnt;
    assign bus.ana_gnt  = ana_gnt;

    always_ff @(posedge clk_25_vga or negedge rst_n) begin
        if (!rst_n)
            bus.bram_rdaddress <= '0;
        else if (disp_gnt)
            bus.bram_rdaddress <= bus.disp_addr;
        else if (ana_gnt)
            bus.bram_rdaddress <= bus.ana_addr;
    end

    fbuf_tag_pipe #(
        .DEPTH (RD_LATENCY + 1)
    ) u_tag_pipe (
        .clk_25_vga (clk_25_vga),
        .rst_n      (rst_n),
        .tag_in     (grant_owner(disp_gnt, ana_gnt)),
        .tag_out    (tag_out)
    );

    assign bus.disp_rvalid = (tag_out == OWN_DISP);
    assign bus.ana_rvalid  = (tag_out == OWN_ANA);
    assign bus.disp_rdata  = bus.disp_rvalid ? bus.bram_rddata : '0;
    assign bus.ana_rdata   = bus.ana_rvalid  ? bus.bram_rddata : '0;

endmodule

// File: tb/tb_fbuf_read_arbiter.sv
// Directed bench for fbuf_read_arbiter (RD_LATENCY=2, STARVE_LIMIT=4) with a 2-cycle BRAM model.
module tb_fbuf_read_arbiter;

    logic clk_25_vga = 1'b0;
    logic rst_n      = 1'b0;
    int   n_tests    = 0;
    int   n_fail     = 0;

    always #20 clk_25_vga = ~clk_25_vga;

    fbuf_read_arbiter_if #(.ADDR_BITS(17), .DATA_BITS(12)) bus ();

    fbuf_read_arbiter #(
        .ADDR_BITS    (17),
        .DATA_BITS    (12),
        .RD_LATENCY   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_25_vga (clk_25_vga),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    function automatic logic [11:0] pix(input logic [16:0] a);
        return a[11:0] ^ 12'hA5C;
    endfunction

    // BRAM: data for the address seen in cycle K appears in cycle K+2
    logic [16:0] d1 = '0;
    logic [16:0] d2 = '0;
    always @(posedge clk_25_vga) begin
        d1 <= bus.bram_rdaddress;
        d2 <= d1;
    end
    assign bus.bram_rddata = pix(d2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tg,
                       input logic dr, input logic [16:0] da,
                       input logic ar, input logic [16:0] aa,
                       input logic edg, input logic eag, input logic est,
                       input logic edv, input logic [16:0] edx,
                       input logic eav, input logic [16:0] eax);
        bus.disp_req  = dr;
        bus.disp_addr = da;
        bus.ana_req   = ar;
        bus.ana_addr  = aa;
        @(negedge clk_25_vga);
        chk({tg, ".disp_gnt"},    32'(bus.disp_gnt),    32'(edg));
        chk({tg, ".ana_gnt"},     32'(bus.ana_gnt),     32'(eag));
        chk({tg, ".ana_starved"}, 32'(bus.ana_starved), 32'(est));
        chk({tg, ".disp_rvalid"}, 32'(bus.disp_rvalid), 32'(edv));
        chk({tg, ".disp_rdata"},  32'(bus.disp_rdata),  edv ? 32'(pix(edx)) : 32'd0);
        chk({tg, ".ana_rvalid"},  32'(bus.ana_rvalid),  32'(eav));
        chk({tg, ".ana_rdata"},   32'(bus.ana_rdata),   eav ? 32'(pix(eax)) : 32'd0);
        @(posedge clk_25_vga);
        #1;
    endtask

    task automatic idle(input int n);
        bus.disp_req = 1'b0;
        bus.ana_req  = 1'b0;
        repeat (n) @(posedge clk_25_vga);
        #1;
    endtask

    task automatic chk_all_zero(input string tg);
        chk({tg, ".disp_gnt"},    32'(bus.disp_gnt),       32'd0);
        chk({tg, ".ana_gnt"},     32'(bus.ana_gnt),        32'd0);
        chk({tg, ".rdaddress"},   32'(bus.bram_rdaddress), 32'd0);
        chk({tg, ".disp_rvalid"}, 32'(bus.disp_rvalid),    32'd0);
        chk({tg, ".ana_rvalid"},  32'(bus.ana_rvalid),     32'd0);
        chk({tg, ".disp_rdata"},  32'(bus.disp_rdata),     32'd0);
        chk({tg, ".ana_rdata"},   32'(bus.ana_rdata),      32'd0);
        chk({tg, ".ana_starved"}, 32'(bus.ana_starved),    32'd0);
    endtask

    initial begin
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h00AAA;
        bus.ana_req   = 1'b1;
        bus.ana_addr  = 17'h00BBB;
        repeat (3) @(posedge clk_25_vga);
        @(negedge clk_25_vga);
        chk_all_zero("reset");
        bus.disp_req = 1'b0;
        bus.ana_req  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk_25_vga);
        #1;
        idle(2);

        // Display stream of four addresses
        for (int c = 0; c < 7; c++) begin
            cyc("disp_stream", c < 4, 17'(c), 1'b0, 17'h0,
                c < 4, 1'b0, 1'b0,
                c >= 3, 17'(c - 3), 1'b0, 17'h0);
            chk("disp_stream.rdaddress", 32'(bus.bram_rdaddress), (c < 4) ? 32'(c) : 32'd3);
        end
        idle(4);

        // Analysis alone at the last frame-buffer word
        for (int c = 0; c < 5; c++) begin
            cyc("ana_only", 1'b0, 17'h0, c == 0, 17'h12BFF,
                1'b0, c == 0, 1'b0,
                1'b0, 17'h0, c == 3, 17'h12BFF);
            if (c == 0)
                chk("ana_only.rdaddress", 32'(bus.bram_rdaddress), 32'h12BFF);
        end
        idle(4);

`ifdef FBUF_ARB_STARVE_GUARD_EN
        // Contention: four display grants, one forced analysis slot, display resumes
        for (int c = 0; c < 10; c++) begin
            cyc("starve", c < 6, 17'h100, c < 6, 17'h200,
                (c < 4) || (c == 5), c == 4, c == 4,
                (c >= 3 && c <= 6) || (c == 8), 17'h100,
                c == 7, 17'h200);
        end
`else
        // Strict priority: analysis never wins against display
        for (int c = 0; c < 23; c++) begin
            cyc("strict", c < 20, 17'h100, c < 20, 17'h200,
                c < 20, 1'b0, 1'b0,
                c >= 3, 17'h100, 1'b0, 17'h0);
        end
`endif
        idle(4);

        // Reset one cycle after a display grant discards the in-flight read
        bus.disp_req  = 1'b1;
        bus.disp_addr = 17'h00055;
        bus.ana_req   = 1'b0;
        @(posedge clk_25_vga);
        #1;
        bus.ana_req  = 1'b1;
        bus.ana_addr = 17'h00066;
        rst_n = 1'b0;
        #2;
        chk_all_zero("midreset");
        bus.disp_req = 1'b0;
        bus.ana_req  = 1'b0;
        @(negedge clk_25_vga);
        rst_n = 1'b1;
        @(posedge clk_25_vga);
        #1;
        for (int c = 0; c < 6; c++) begin
            cyc("after_reset", 1'b0, 17'h0, 1'b0, 17'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 17'h0, 1'b0, 17'h0);
        end

        // Alternating owners every cycle, returns must interleave without gaps
        for (int c = 0; c < 9; c++) begin
            cyc("alternate",
                (c < 6) && (c % 2 == 0), 17'(32'h10 + c),
                (c < 6) && (c % 2 == 1), 17'(32'h20 + c),
                (c < 6) && (c % 2 == 0), (c < 6) && (c % 2 == 1), 1'b0,
                (c >= 3) && ((c - 3) % 2 == 0), 17'(32'h10 + c - 3),
                (c >= 3) && ((c - 3) % 2 == 1), 17'(32'h20 + c - 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
